side_info_packer: RTL and testbench
===================================

Name: side_info_packer

Overview:
- Transmit-side counterpart of the Layer III side-info parser.
- Takes decoded MPEG-1 Layer III stereo side-info fields for 2 granules x 2 channels, 256 bits total, and serialises them MSB-first as 32 bytes on a byte-wide valid/ready stream.
- Sits between the frame-assembly controller and the byte-stream muxer that follows the 4-byte frame header.

Parameters:
- SIDE_BYTES, 32, side-info length in bytes. Only 32 (stereo MPEG-1) is supported. Sets byte-counter terminal value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request; snapshot fields and begin sending (honoured only when idle)
- main_data_begin  in  9  main data back-pointer
- private_bits  in  3  private bits
- scfsi  in  [1:0][3:0] x1  scale-factor select info [ch][band]
- part2_3_length  in  [1:0][1:0] x12  indexed [gr][ch]; same indexing for all per-granule fields below
- big_values  in  [gr][ch] x9
- global_gain  in  [gr][ch] x8
- scalefac_compress  in  [gr][ch] x4
- window_switching_flag  in  [gr][ch] x1
- block_type  in  [gr][ch] x2
- mixed_block_flag  in  [gr][ch] x1
- table_select  in  [gr][ch][2:0] x5
- subblock_gain  in  [gr][ch][2:0] x3
- region0_count  in  [gr][ch] x4  coded value
- region1_count  in  [gr][ch] x3  coded value
- preflag, scalefac_scale, count1table_select  in  [gr][ch] x1 each
- axiod  out  8  output byte
- axiov  out  1  output byte valid
- axiir  in  1  downstream ready
- busy  out  1  high while in SEND
- done  out  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, shift register=0, byte count=0. axiod=0, axiov=0, busy=0, done=0. Reset mid-stream abandons the frame; no further bytes are emitted.
- Bit order of the 256-bit vector, transmitted from bit 255 first:
  - main_data_begin[8:0], private_bits[2:0]
  - scfsi[0][0..3], scfsi[1][0..3]
  - then 59-bit blocks in order gr0ch0, gr0ch1, gr1ch0, gr1ch1
- Each 59-bit block: part2_3_length(12), big_values(9), global_gain(8), scalefac_compress(4), window_switching_flag(1), then a 22-bit conditional section, then preflag, scalefac_scale, count1table_select.
- Conditional section:
  - wsf=1: block_type(2), mixed_block_flag(1), table_select[0..1](5 each), subblock_gain[0..2](3 each).
  - wsf=0: table_select[0..2](5 each), region0_count(4), region1_count(3).
  - Fields unused for the active branch are ignored.
- IDLE: if start=1, assemble the vector combinationally and register it; go to SEND, busy=1, count=0. On the next cycle axiov=1 and axiod=vector[255:248]. Latency start->first valid = 1 cycle.
- SEND:
  - axiov=1 continuously.
  - A transfer occurs when axiov and axiir are both 1; the register shifts left 8 and count increments.
  - With axiir=0, axiod and count hold stable.
  - On the transfer with count=SIDE_BYTES-1: next cycle axiov=0, busy=0, done=1 for exactly one cycle, state=IDLE.
- start during SEND, including the final-transfer cycle, is ignored; inputs are not re-sampled. start asserted in the done cycle is accepted (state is IDLE).
- Input fields need only be stable in the start cycle.
- With axiir held 1 throughout, a frame takes exactly 32 valid cycles.

Test Plan:
- All fields 0 except main_data_begin=9'h1FF, private_bits=3'b101, scfsi[0][0]=1 -> byte0=0xFF, byte1=0xD8, bytes2..31=0x00; done one cycle after byte31 accepted.
- part2_3_length[0][0]=12'hABC, rest 0 -> byte2=0x0A, byte3=0xBC, all others 0x00.
- window_switching_flag[0][0]=1, block_type[0][0]=2'b10, region0_count[0][0]=4'hF -> byte6=0x06; region0_count does not appear anywhere (all other bytes 0x00).
- Backpressure: axiir toggled 1,0,0,1 repeatedly -> exactly 32 transfers; axiod unchanged across every axiir=0 cycle; byte sequence identical to the axiir-always-1 case.
- start pulsed at byte 10 with different field values -> stream continues with the original frame; no second frame follows done.
- rst_n=0 at byte 15 -> axiov=0, busy=0, done=0 next cycle. A subsequent start sends a full fresh 32-byte frame from byte0.

Source files
------------

// File: rtl/side_info_packer.sv
// Serialises MPEG-1 Layer III stereo side info (2 granules x 2 channels, 256 bits)
// MSB-first as 32 bytes on a byte-wide valid/ready stream.
module side_info_packer #(
    parameter int SIDE_BYTES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8:0]            main_data_begin,
    input  logic [2:0]            private_bits,
    input  logic [1:0][3:0]       scfsi,
    input  logic [1:0][1:0][11:0] part2_3_length,
    input  logic [1:0][1:0][8:0]  big_values,
    input  logic [1:0][1:0][7:0]  global_gain,
    input  logic [1:0][1:0][3:0]  scalefac_compress,
    input  logic [1:0][1:0]       window_switching_flag,
    input  logic [1:0][1:0][1:0]  block_type,
    input  logic [1:0][1:0]       mixed_block_flag,
    input  logic [1:0][1:0][2:0][4:0] table_select,
    input  logic [1:0][1:0][2:0][2:0] subblock_gain,
    input  logic [1:0][1:0][3:0]  region0_count,
    input  logic [1:0][1:0][2:0]  region1_count,
    input  logic [1:0][1:0]       preflag,
    input  logic [1:0][1:0]       scalefac_scale,
    input  logic [1:0][1:0]       count1table_select,
    output logic [7:0]            axiod,
    output logic                  axiov,
    input  logic                  axiir,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [4:0] LAST_CNT = 5'(SIDE_BYTES - 1);

    state_t       state_r, state_s;
    logic [255:0] sr_r, sr_s;
    logic [4:0]   cnt_r, cnt_s;
    logic         done_r, done_s;
    logic [255:0] vector_s;
    logic [58:0]  blk_s [4];

    // One granule/channel block; the 22-bit middle section depends on window switching.
    function automatic logic [58:0] pack_block(
        input logic [11:0]     p23,
        input logic [8:0]      bv,
        input logic [7:0]      gg,
        input logic [3:0]      sc,
        input logic            wsf,
        input logic [1:0]      bt,
        input logic            mbf,
        input logic [2:0][4:0] ts,
        input logic [2:0][2:0] sg,
        input logic [3:0]      r0,
        input logic [2:0]      r1,
        input logic            pf,
        input logic            ss,
        input logic            c1
    );
        logic [21:0] cond;
        if (wsf) begin
            cond = {bt, mbf, ts[0], ts[1], sg[0], sg[1], sg[2]};
        end else begin
            cond = {ts[0], ts[1], ts[2], r0, r1};
        end
        return {p23, bv, gg, sc, wsf, cond, pf, ss, c1};
    endfunction

    // Assemble the full 256-bit side-info vector from the live input fields.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            blk_s[i] = pack_block(part2_3_length[i/2][i%2], big_values[i/2][i%2],
                                  global_gain[i/2][i%2], scalefac_compress[i/2][i%2],
                                  window_switching_flag[i/2][i%2], block_type[i/2][i%2],
                                  mixed_block_flag[i/2][i%2], table_select[i/2][i%2],
                                  subblock_gain[i/2][i%2], region0_count[i/2][i%2],
                                  region1_count[i/2][i%2], preflag[i/2][i%2],
                                  scalefac_scale[i/2][i%2], count1table_select[i/2][i%2]);
        end
        vector_s = {main_data_begin, private_bits,
                    scfsi[0][0], scfsi[0][1], scfsi[0][2], scfsi[0][3],
                    scfsi[1][0], scfsi[1][1], scfsi[1][2], scfsi[1][3],
                    blk_s[0], blk_s[1], blk_s[2], blk_s[3]};
    end

    // Next-state logic: snapshot on start, shift one byte per accepted transfer.
    always_comb begin
        state_s = state_r;
        sr_s    = sr_r;
        cnt_s   = cnt_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SEND;
                    sr_s    = vector_s;
                    cnt_s   = 5'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (axiir) begin
                    sr_s = {sr_r[247:0], 8'h00};
                    if (cnt_r == LAST_CNT) begin
                        state_s = ST_IDLE;
                        cnt_s   = 5'd0;
                        done_s  = 1'b1;
                    end else begin
                        cnt_s = cnt_r + 5'd1;
                    end
                end else begin
                    sr_s = sr_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 5'd0;
            end
        endcase
    end

    // State, shift register, counter and done pulse with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            sr_r    <= 256'd0;
            cnt_r   <= 5'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sr_r    <= sr_s;
            cnt_r   <= cnt_s;
            done_r  <= done_s;
        end
    end

    assign axiod = sr_r[255:248];
    assign axiov = (state_r == ST_SEND);
    assign busy  = (state_r == ST_SEND);
    assign done  = done_r;

endmodule

// File: tb/tb_side_info_packer.sv
// Scoreboard bench for side_info_packer: directed frames, backpressure,
// start-while-busy and mid-frame reset.
module tb_side_info_packer;

    logic                  clk = 1'b0;
    logic                  rst_n, start, axiir;
    logic [8:0]            main_data_begin;
    logic [2:0]            private_bits;
    logic [1:0][3:0]       scfsi;
    logic [1:0][1:0][11:0] part2_3_length;
    logic [1:0][1:0][8:0]  big_values;
    logic [1:0][1:0][7:0]  global_gain;
    logic [1:0][1:0][3:0]  scalefac_compress;
    logic [1:0][1:0]       window_switching_flag;
    logic [1:0][1:0][1:0]  block_type;
    logic [1:0][1:0]       mixed_block_flag;
    logic [1:0][1:0][2:0][4:0] table_select;
    logic [1:0][1:0][2:0][2:0] subblock_gain;
    logic [1:0][1:0][3:0]  region0_count;
    logic [1:0][1:0][2:0]  region1_count;
    logic [1:0][1:0]       preflag, scalefac_scale, count1table_select;
    logic [7:0]            axiod;
    logic                  axiov, busy, done;

    int         checks = 0;
    int         errors = 0;
    int         rx_idx = 0;
    int         bp_ph  = 0;
    bit         bp_mode = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_bytes [32];

    always #5 clk = ~clk;

    side_info_packer #(.SIDE_BYTES(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .main_data_begin(main_data_begin), .private_bits(private_bits), .scfsi(scfsi),
        .part2_3_length(part2_3_length), .big_values(big_values), .global_gain(global_gain),
        .scalefac_compress(scalefac_compress), .window_switching_flag(window_switching_flag),
        .block_type(block_type), .mixed_block_flag(mixed_block_flag),
        .table_select(table_select), .subblock_gain(subblock_gain),
        .region0_count(region0_count), .region1_count(region1_count),
        .preflag(preflag), .scalefac_scale(scalefac_scale),
        .count1table_select(count1table_select),
        .axiod(axiod), .axiov(axiov), .axiir(axiir), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready: always 1, or the 1,0,0,1 pattern in backpressure mode.
    initial begin
        axiir = 1'b1;
        forever begin
            tick();
            if (bp_mode) begin
                axiir = (bp_ph == 0 || bp_ph == 3);
                bp_ph = (bp_ph + 1) % 4;
            end else begin
                axiir = 1'b1;
                bp_ph = 0;
            end
        end
    end

    // Monitor: pops expected bytes on each transfer, checks hold-under-stall and done timing.
    initial begin
        logic       stall_prev;
        logic [7:0] d_prev;
        logic       pend;
        logic [7:0] e;
        stall_prev = 1'b0;
        d_prev     = 8'h00;
        pend       = 1'b0;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                chk("hold_valid", {31'd0, axiov}, 32'd1);
                chk("hold_data", {24'd0, axiod}, {24'd0, d_prev});
            end
            chk("done_timing", {31'd0, done}, {31'd0, pend});
            pend = 1'b0;
            if (rst_n && axiov && axiir) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_byte: got %02h expected no transfer", axiod);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("byte%0d", rx_idx), {24'd0, axiod}, {24'd0, e});
                    pend   = (rx_idx == 31);
                    rx_idx = (rx_idx == 31) ? 0 : rx_idx + 1;
                end
            end
            stall_prev = rst_n && axiov && !axiir;
            d_prev     = axiod;
        end
    end

    task automatic clear_fields();
        main_data_begin = '0; private_bits = '0; scfsi = '0;
        part2_3_length = '0; big_values = '0; global_gain = '0; scalefac_compress = '0;
        window_switching_flag = '0; block_type = '0; mixed_block_flag = '0;
        table_select = '0; subblock_gain = '0; region0_count = '0; region1_count = '0;
        preflag = '0; scalefac_scale = '0; count1table_select = '0;
    endtask

    task automatic exp_zero();
        for (int i = 0; i < 32; i++) exp_bytes[i] = 8'h00;
    endtask

    task automatic push_exp();
        for (int i = 0; i < 32; i++) exp_q.push_back(exp_bytes[i]);
    endtask

    task automatic fields_t1();
        clear_fields();
        main_data_begin = 9'h1FF;
        private_bits    = 3'b101;
        scfsi[0][0]     = 1'b1;
        exp_zero();
        exp_bytes[0] = 8'hFF;
        exp_bytes[1] = 8'hD8;
    endtask

    task automatic fields_t2();
        clear_fields();
        part2_3_length[0][0] = 12'hABC;
        exp_zero();
        exp_bytes[2] = 8'h0A;
        exp_bytes[3] = 8'hBC;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("first_valid_latency", {31'd0, axiov}, 32'd1);
        chk("busy_in_send", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("idle_after_done", {30'd0, busy, axiov}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic wait_idx(input int k);
        int n;
        n = 0;
        while (rx_idx != k && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk($sformatf("reach_byte%0d", k), rx_idx, k);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_fields();
        repeat (3) tick();
        chk("reset_outputs", {21'd0, axiod, axiov, busy, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Header fields and scfsi
        fields_t1(); push_exp(); pulse_start(); wait_done(); tick();

        // part2_3_length of gr0ch0
        fields_t2(); push_exp(); pulse_start(); wait_done(); tick();

        // Window-switching branch hides region0_count
        clear_fields();
        window_switching_flag[0][0] = 1'b1;
        block_type[0][0]            = 2'b10;
        region0_count[0][0]         = 4'hF;
        exp_zero();
        exp_bytes[6] = 8'h06;
        push_exp(); pulse_start(); wait_done(); tick();

        // Normal branch in the last block: table_select[2], region1_count, count1table_select
        clear_fields();
        table_select[1][1][2]    = 5'h1F;
        region1_count[1][1]      = 3'b111;
        count1table_select[1][1] = 1'b1;
        exp_zero();
        exp_bytes[30] = 8'h7C;
        exp_bytes[31] = 8'h39;
        push_exp(); pulse_start(); wait_done(); tick();

        // Backpressure 1,0,0,1
        bp_mode = 1'b1;
        fields_t1(); push_exp(); pulse_start(); wait_done();
        bp_mode = 1'b0;
        tick();

        // start while sending is ignored; no second frame
        fields_t2(); push_exp(); pulse_start();
        wait_idx(10);
        main_data_begin = 9'h155;
        part2_3_length  = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        repeat (6) tick();
        chk("no_second_frame", {30'd0, axiov, busy}, 32'd0);

        // Reset mid-frame, then a fresh frame
        fields_t1(); push_exp(); pulse_start();
        wait_idx(15);
        rst_n = 1'b0;
        tick();
        chk("reset_mid_frame", {29'd0, axiov, busy, done}, 32'd0);
        exp_q.delete();
        rx_idx = 0;
        rst_n = 1'b1;
        tick();
        fields_t1(); push_exp(); pulse_start(); wait_done();

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
